// File: rtl/core_register_bank.sv
// core_register_bank: Cortex-M0 core register file (R0-R12, MSP, LR, PC,
// APSR, IPSR, PRIMASK) driven by control-unit write strobes.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   ld_sp/ld_lr/ld_pc/ld_rd   - word write strobes (data on wr_data, rd_addr for ld_rd)
//   ld_apsr/ld_ipsr/ld_primask- PSR / mask write strobes (nzcv_in, ipsr_in, primask_in)
//   inc_pc                    - Thumb sequential PC advance (+2)
//   ra_addr/rb_addr -> ra_data/rb_data : combinational operand read ports
//   sp_out/lr_out/pc_out/apsr_out/ipsr_out/primask_out : special register views
//   wr_conflict               - registered pulse for a resolved same-register write collision
module core_register_bank #(
    parameter logic [31:0] RESET_SP = 32'h2000_1000,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_sp,
    input  logic        ld_lr,
    input  logic        ld_pc,
    input  logic        ld_rd,
    input  logic        ld_apsr,
    input  logic        ld_ipsr,
    input  logic        ld_primask,
    input  logic        inc_pc,
    input  logic [3:0]  rd_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  nzcv_in,
    input  logic [5:0]  ipsr_in,
    input  logic        primask_in,
    input  logic [3:0]  ra_addr,
    input  logic [3:0]  rb_addr,
    output logic [31:0] ra_data,
    output logic [31:0] rb_data,
    output logic [31:0] sp_out,
    output logic [31:0] lr_out,
    output logic [31:0] pc_out,
    output logic [31:0] apsr_out,
    output logic [31:0] ipsr_out,
    output logic        primask_out,
    output logic        wr_conflict
);

    localparam int unsigned NUM_GPR  = 13;
    localparam int unsigned XLEN     = 32;
    localparam logic [3:0]  ADDR_SP  = 4'd13;
    localparam logic [3:0]  ADDR_LR  = 4'd14;
    localparam logic [3:0]  ADDR_PC  = 4'd15;
    localparam logic [XLEN-1:0] SP_MASK   = 32'hFFFF_FFFC;
    localparam logic [XLEN-1:0] PC_MASK   = 32'hFFFF_FFFE;
    localparam logic [XLEN-1:0] SP_RESET  = RESET_SP & SP_MASK;
    localparam logic [XLEN-1:0] PC_RESET  = RESET_PC & PC_MASK;
    localparam logic [XLEN-1:0] LR_RESET  = 32'hFFFF_FFFF;

    logic [XLEN-1:0] gpr_q [NUM_GPR];
    logic [XLEN-1:0] gpr_d [NUM_GPR];
    logic [XLEN-1:0] sp_q, sp_d;
    logic [XLEN-1:0] lr_q, lr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [3:0]      nzcv_q, nzcv_d;
    logic [5:0]      ipsr_q, ipsr_d;
    logic            primask_q, primask_d;
    logic            wr_conflict_q, wr_conflict_d;

    logic rd_hits_sp, rd_hits_lr, rd_hits_pc;

    // Decode of ld_rd onto the special-register slots of the address map
    assign rd_hits_sp = ld_rd && (rd_addr == ADDR_SP);
    assign rd_hits_lr = ld_rd && (rd_addr == ADDR_LR);
    assign rd_hits_pc = ld_rd && (rd_addr == ADDR_PC);

    // Next-state: all independent strobes commit together; colliding
    // writers carry identical data so only the conflict flag differs
    always_comb begin
        for (int i = 0; i < NUM_GPR; i++) begin
            gpr_d[i] = gpr_q[i];
        end
        sp_d          = sp_q;
        lr_d          = lr_q;
        pc_d          = pc_q;
        nzcv_d        = nzcv_q;
        ipsr_d        = ipsr_q;
        primask_d     = primask_q;
        wr_conflict_d = 1'b0;

        for (int i = 0; i < NUM_GPR; i++) begin
            if (ld_rd && (rd_addr == 4'(i))) begin
                gpr_d[i] = wr_data;
            end
        end

        if (ld_sp || rd_hits_sp) begin
            sp_d = wr_data & SP_MASK;
        end
        if (ld_lr || rd_hits_lr) begin
            lr_d = wr_data;
        end
        // Explicit PC write overrides sequential advance
        if (ld_pc || rd_hits_pc) begin
            pc_d = wr_data & PC_MASK;
        end else if (inc_pc) begin
            pc_d = pc_q + 32'd2;
        end

        if (ld_apsr) begin
            nzcv_d = nzcv_in;
        end
        if (ld_ipsr) begin
            ipsr_d = ipsr_in;
        end
        if (ld_primask) begin
            primask_d = primask_in;
        end

        wr_conflict_d = (ld_sp && rd_hits_sp) || (ld_lr && rd_hits_lr) ||
                        (ld_pc && rd_hits_pc);
    end

    // State register with synchronous reset overriding every strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr_q[i] <= '0;
            end
            sp_q          <= SP_RESET;
            lr_q          <= LR_RESET;
            pc_q          <= PC_RESET;
            nzcv_q        <= '0;
            ipsr_q        <= '0;
            primask_q     <= 1'b0;
            wr_conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
            sp_q          <= sp_d;
            lr_q          <= lr_d;
            pc_q          <= pc_d;
            nzcv_q        <= nzcv_d;
            ipsr_q        <= ipsr_d;
            primask_q     <= primask_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    // Read port mux; PC reads as PC + 4 (Thumb pipeline view)
    function automatic logic [XLEN-1:0] read_reg(input logic [3:0] addr);
        logic [XLEN-1:0] val;
        val = '0;
        case (addr)
            ADDR_SP: val = sp_q;
            ADDR_LR: val = lr_q;
            ADDR_PC: val = pc_q + 32'd4;
            default: begin
                for (int i = 0; i < NUM_GPR; i++) begin
                    if (addr == 4'(i)) begin
                        val = gpr_q[i];
                    end
                end
            end
        endcase
        return val;
    endfunction

    assign ra_data     = read_reg(ra_addr);
    assign rb_data     = read_reg(rb_addr);
    assign sp_out      = sp_q;
    assign lr_out      = lr_q;
    assign pc_out      = pc_q;
    assign apsr_out    = {nzcv_q, 28'd0};
    assign ipsr_out    = {26'd0, ipsr_q};
    assign primask_out = primask_q;
    assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_core_register_bank.sv
// Directed self-checking bench for core_register_bank.
module tb_core_register_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_sp, ld_lr, ld_pc, ld_rd;
    logic        ld_apsr, ld_ipsr, ld_primask, inc_pc;
    logic [3:0]  rd_addr;
    logic [31:0] wr_data;
    logic [3:0]  nzcv_in;
    logic [5:0]  ipsr_in;
    logic        primask_in;
    logic [3:0]  ra_addr, rb_addr;
    logic [31:0] ra_data, rb_data;
    logic [31:0] sp_out, lr_out, pc_out, apsr_out, ipsr_out;
    logic        primask_out, wr_conflict;

    int checks = 0;
    int fails  = 0;

    core_register_bank dut (
        .clk(clk), .rst(rst),
        .ld_sp(ld_sp), .ld_lr(ld_lr), .ld_pc(ld_pc), .ld_rd(ld_rd),
        .ld_apsr(ld_apsr), .ld_ipsr(ld_ipsr), .ld_primask(ld_primask),
        .inc_pc(inc_pc), .rd_addr(rd_addr), .wr_data(wr_data),
        .nzcv_in(nzcv_in), .ipsr_in(ipsr_in), .primask_in(primask_in),
        .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(ra_data), .rb_data(rb_data),
        .sp_out(sp_out), .lr_out(lr_out), .pc_out(pc_out),
        .apsr_out(apsr_out), .ipsr_out(ipsr_out),
        .primask_out(primask_out), .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    task automatic clear_strobes();
        rst = 1'b0; ld_sp = 1'b0; ld_lr = 1'b0; ld_pc = 1'b0; ld_rd = 1'b0;
        ld_apsr = 1'b0; ld_ipsr = 1'b0; ld_primask = 1'b0; inc_pc = 1'b0;
        rd_addr = 4'd0; wr_data = 32'd0; nzcv_in = 4'd0; ipsr_in = 6'd0;
        primask_in = 1'b0;
    endtask

    // Advance one edge; outputs are then sampled 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_strobes();
        ra_addr = 4'd0; rb_addr = 4'd0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (sp_out !== 32'h2000_1000) begin fails++; $display("FAIL reset_sp got %h want %h", sp_out, 32'h2000_1000); end
        checks++; if (lr_out !== 32'hFFFF_FFFF) begin fails++; $display("FAIL reset_lr got %h want %h", lr_out, 32'hFFFF_FFFF); end
        checks++; if (pc_out !== 32'h0) begin fails++; $display("FAIL reset_pc got %h want %h", pc_out, 32'h0); end
        checks++; if (wr_conflict !== 1'b0) begin fails++; $display("FAIL reset_conflict got %b want 0", wr_conflict); end
        checks++; if (apsr_out !== 32'h0 || ipsr_out !== 32'h0 || primask_out !== 1'b0) begin
            fails++; $display("FAIL reset_psr got %h %h %b want 0 0 0", apsr_out, ipsr_out, primask_out); end
        ra_addr = 4'd15; #1;
        checks++; if (ra_data !== 32'h0000_0004) begin fails++; $display("FAIL reset_ra_pc got %h want %h", ra_data, 32'h4); end
        for (int i = 0; i < 13; i++) begin
            ra_addr = 4'(i); rb_addr = 4'(12 - i); #1;
            checks++; if (ra_data !== 32'h0 || rb_data !== 32'h0) begin
                fails++; $display("FAIL reset_gpr%0d got %h %h want 0", i, ra_data, rb_data); end
        end
    endtask

    task automatic test_write_strobes();
        clear_strobes();
        ld_sp = 1'b1; wr_data = 32'h2000_0FFF;
        step(); clear_strobes();
        checks++; if (sp_out !== 32'h2000_0FFC) begin fails++; $display("FAIL sp_mask got %h want %h", sp_out, 32'h2000_0FFC); end
        rb_addr = 4'd13; #1;
        checks++; if (rb_data !== 32'h2000_0FFC) begin fails++; $display("FAIL rb_sp got %h want %h", rb_data, 32'h2000_0FFC); end
        ld_rd = 1'b1; rd_addr = 4'd3; wr_data = 32'hDEAD_BEEF; ra_addr = 4'd3; #1;
        checks++; if (ra_data !== 32'h0) begin fails++; $display("FAIL raw_old got %h want %h", ra_data, 32'h0); end
        step(); clear_strobes();
        checks++; if (ra_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL gpr3_write got %h want %h", ra_data, 32'hDEAD_BEEF); end
        ld_lr = 1'b1; wr_data = 32'h0000_0003;
        step(); clear_strobes();
        checks++; if (lr_out !== 32'h0000_0003) begin fails++; $display("FAIL lr_full got %h want %h", lr_out, 32'h3); end
    endtask

    task automatic test_pc_seq();
        clear_strobes();
        inc_pc = 1'b1;
        step(); step(); step();
        clear_strobes();
        checks++; if (pc_out !== 32'h6) begin fails++; $display("FAIL pc_inc3 got %h want %h", pc_out, 32'h6); end
        ra_addr = 4'd15; #1;
        checks++; if (ra_data !== 32'hA) begin fails++; $display("FAIL ra_pc4 got %h want %h", ra_data, 32'hA); end
        ld_pc = 1'b1; inc_pc = 1'b1; wr_data = 32'h0000_0101;
        step(); clear_strobes();
        checks++; if (pc_out !== 32'h100) begin fails++; $display("FAIL pc_ld_beats_inc got %h want %h", pc_out, 32'h100); end
        checks++; if (wr_conflict !== 1'b0) begin fails++; $display("FAIL pc_inc_no_conflict got %b want 0", wr_conflict); end
        ld_rd = 1'b1; rd_addr = 4'd15; inc_pc = 1'b1; wr_data = 32'h0000_0203;
        step(); clear_strobes();
        checks++; if (pc_out !== 32'h202) begin fails++; $display("FAIL pc_rd15_beats_inc got %h want %h", pc_out, 32'h202); end
        ld_pc = 1'b1; wr_data = 32'hFFFF_FFFE;
        step(); clear_strobes();
        inc_pc = 1'b1;
        step(); clear_strobes();
        checks++; if (pc_out !== 32'h0) begin fails++; $display("FAIL pc_wrap got %h want %h", pc_out, 32'h0); end
    endtask

    task automatic test_collision();
        clear_strobes();
        ld_sp = 1'b1; ld_rd = 1'b1; rd_addr = 4'd13; wr_data = 32'h1234_5678;
        step(); clear_strobes();
        checks++; if (sp_out !== 32'h1234_5678) begin fails++; $display("FAIL coll_sp got %h want %h", sp_out, 32'h1234_5678); end
        checks++; if (wr_conflict !== 1'b1) begin fails++; $display("FAIL coll_flag got %b want 1", wr_conflict); end
        step();
        checks++; if (wr_conflict !== 1'b0) begin fails++; $display("FAIL coll_pulse got %b want 0", wr_conflict); end
        ld_lr = 1'b1; ld_rd = 1'b1; rd_addr = 4'd14; wr_data = 32'hCAFE_F00D;
        step(); clear_strobes();
        checks++; if (lr_out !== 32'hCAFE_F00D || wr_conflict !== 1'b1) begin
            fails++; $display("FAIL coll_lr got %h %b want %h 1", lr_out, wr_conflict, 32'hCAFE_F00D); end
        ld_pc = 1'b1; ld_rd = 1'b1; rd_addr = 4'd15; wr_data = 32'h0000_0401;
        step(); clear_strobes();
        checks++; if (pc_out !== 32'h400 || wr_conflict !== 1'b1) begin
            fails++; $display("FAIL coll_pc got %h %b want %h 1", pc_out, wr_conflict, 32'h400); end
        ld_sp = 1'b1; ld_rd = 1'b1; rd_addr = 4'd4; wr_data = 32'h0000_0055;
        step(); clear_strobes();
        checks++; if (wr_conflict !== 1'b0) begin fails++; $display("FAIL no_coll_diff got %b want 0", wr_conflict); end
    endtask

    task automatic test_psr();
        clear_strobes();
        ld_apsr = 1'b1; nzcv_in = 4'b1010;
        ld_ipsr = 1'b1; ipsr_in = 6'h3F;
        ld_primask = 1'b1; primask_in = 1'b1;
        step(); clear_strobes();
        checks++; if (apsr_out !== 32'hA000_0000) begin fails++; $display("FAIL apsr got %h want %h", apsr_out, 32'hA000_0000); end
        checks++; if (ipsr_out !== 32'h0000_003F) begin fails++; $display("FAIL ipsr got %h want %h", ipsr_out, 32'h3F); end
        checks++; if (primask_out !== 1'b1) begin fails++; $display("FAIL primask got %b want 1", primask_out); end
    endtask

    task automatic test_independent();
        clear_strobes();
        // pc_out is 0x400 from the collision test
        ld_sp = 1'b1; ld_rd = 1'b1; rd_addr = 4'd3; ld_apsr = 1'b1; inc_pc = 1'b1;
        wr_data = 32'h3000_0007; nzcv_in = 4'b0101; ra_addr = 4'd3;
        step(); clear_strobes();
        checks++; if (sp_out !== 32'h3000_0004 || ra_data !== 32'h3000_0007 ||
                      apsr_out !== 32'h5000_0000 || pc_out !== 32'h402) begin
            fails++; $display("FAIL independent got sp=%h r3=%h apsr=%h pc=%h want 30000004 30000007 50000000 00000402",
                              sp_out, ra_data, apsr_out, pc_out); end
        checks++; if (wr_conflict !== 1'b0) begin fails++; $display("FAIL independent_conflict got %b want 0", wr_conflict); end
    endtask

    task automatic test_reset_mid();
        clear_strobes();
        ld_rd = 1'b1; rd_addr = 4'd5; wr_data = 32'hFFFF_FFFF;
        step(); clear_strobes();
        ra_addr = 4'd5; #1;
        checks++; if (ra_data !== 32'hFFFF_FFFF) begin fails++; $display("FAIL pre_rst_r5 got %h want %h", ra_data, 32'hFFFF_FFFF); end
        // Reset plus writes and a would-be collision on SP in one cycle
        rst = 1'b1; ld_lr = 1'b1; ld_sp = 1'b1; ld_rd = 1'b1; rd_addr = 4'd13; wr_data = 32'h0;
        step(); clear_strobes();
        checks++; if (ra_data !== 32'h0) begin fails++; $display("FAIL rst_mid_r5 got %h want %h", ra_data, 32'h0); end
        checks++; if (lr_out !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rst_mid_lr got %h want %h", lr_out, 32'hFFFF_FFFF); end
        checks++; if (sp_out !== 32'h2000_1000) begin fails++; $display("FAIL rst_mid_sp got %h want %h", sp_out, 32'h2000_1000); end
        checks++; if (wr_conflict !== 1'b0) begin fails++; $display("FAIL rst_mid_conflict got %b want 0", wr_conflict); end
        checks++; if (primask_out !== 1'b0 || apsr_out !== 32'h0 || pc_out !== 32'h0) begin
            fails++; $display("FAIL rst_mid_misc got %b %h %h want 0 0 0", primask_out, apsr_out, pc_out); end
    endtask

    initial begin
        clear_strobes();
        ra_addr = 4'd0;
        rb_addr = 4'd0;
        test_reset();
        test_write_strobes();
        test_pc_seq();
        test_collision();
        test_psr();
        test_independent();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/core_register_bank.md
# core_register_bank

Cortex-M0 core register bank that executes the load strobes issued by the control unit: R0–R12, SP (MSP only), LR, PC, APSR, IPSR and PRIMASK. It is the write-strobe responder for `ControlUnit` and serves two combinational operand read ports plus dedicated special-register outputs to the datapath. Thumb PC sequencing (`inc_pc`), alignment masking and same-cycle write-conflict arbitration are contained in this block.

## Interface
- `RESET_SP`, default `32'h2000_1000`: SP value loaded on reset; bits [1:0] are forced to 0.
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset; bit 0 is forced to 0.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `ld_sp`, `ld_lr`, `ld_pc`, `ld_rd` input 1 each: write strobes. SP, LR and PC take `wr_data`; `ld_rd` writes `wr_data` to register `rd_addr`.
- `ld_apsr` input 1: write `nzcv_in` to APSR[31:28].
- `ld_ipsr` input 1: write `ipsr_in` to IPSR[5:0].
- `ld_primask` input 1: write `primask_in` to PRIMASK[0].
- `inc_pc` input 1: PC <= PC + 2.
- `rd_addr` input 4: destination for `ld_rd`.
- `wr_data` input 32: write data.
- `nzcv_in` input 4, `ipsr_in` input 6, `primask_in` input 1: PSR and mask write data.
- `ra_addr`, `rb_addr` input 4 each: read port selects.
- `ra_data`, `rb_data` output 32 each: read port data.
- `sp_out`, `lr_out`, `pc_out`, `apsr_out`, `ipsr_out` output 32 each: current register contents.
- `primask_out` output 1: current PRIMASK.
- `wr_conflict` output 1: registered one-cycle pulse flagging a resolved write collision.

## Operation
- **Address map.** 0–12 select R0–R12, 13 selects SP, 14 selects LR, 15 selects PC. `ld_rd` with `rd_addr` 13, 14 or 15 writes SP, LR or PC.
- **Write masking.** Every SP write stores `wr_data & 32'hFFFF_FFFC`. Every PC write stores `wr_data & 32'hFFFF_FFFE`. LR and R0–R12 store the full word.
- **Collision priority.** A dedicated strobe beats `ld_rd` targeting the same register: `ld_sp` beats `ld_rd`@13, `ld_lr` beats `ld_rd`@14, `ld_pc` beats `ld_rd`@15. Both writers carry the same `wr_data`, so the stored value is identical either way; only `wr_conflict` records the collision.
- **PC update priority.** Any PC write (`ld_pc`, or `ld_rd`@15) beats `inc_pc`. The increment is discarded with no conflict flag. `inc_pc` alone: PC <= PC + 2, modulo 2^32, so 32'hFFFF_FFFE wraps to 0.
- **Independent strobes.** Strobes addressing different registers all take effect in the same cycle. Example: `ld_sp`, `ld_rd`@3, `ld_apsr` and `inc_pc` all commit together.
- **PSR reads.** `apsr_out` = {NZCV, 28'b0}. `ipsr_out` = {26'b0, IPSR[5:0]}. Unimplemented bits always read 0.
- **Read ports.** Combinational from registered state, with no write-to-read bypass. Address 15 returns PC + 4 (Thumb read-PC convention); all other addresses return stored contents. `pc_out` returns the raw PC.
- **Reset values** (applied whenever `rst` = 1 at a clock edge, overriding every strobe in that cycle):
  - R0–R12 = 0
  - SP = `RESET_SP` & ~3
  - LR = 32'hFFFF_FFFF
  - PC = `RESET_PC` & ~1
  - APSR = 0, IPSR = 0, PRIMASK = 0
  - `wr_conflict` = 0
- **Reset mid-operation.** Reset discards all pending strobes. There is no partial commit.

## Timing
- **Write latency.** One cycle: a strobe sampled at edge N is visible on `*_out` and the read ports after edge N.
- **Read-after-write.** Same-cycle read-after-write returns the old value. There is no bypass; the datapath owns forwarding.
- **`wr_conflict`.** Asserted for exactly the one cycle following an edge that sampled a collision. It is not sticky. It is 0 during and immediately after reset.
- **Outputs.** Combinational outputs change only after a clock edge and carry no combinational path from any `ld_*` input. `ra_data`/`rb_data` depend combinationally on `ra_addr`/`rb_addr` only.

## Test plan
- **Reset values.** Assert `rst` for 1 cycle with defaults → `sp_out`=0x2000_1000, `lr_out`=0xFFFF_FFFF, `pc_out`=0, `ra_data`@15=0x0000_0004, all R0–R12 read 0, `wr_conflict`=0.
- **Write strobes.** `ld_sp`, `wr_data`=0x2000_0FFF → `sp_out`=0x2000_0FFC. Then `ld_rd`, `rd_addr`=3, 0xDEAD_BEEF → `ra_data`@3=0xDEAD_BEEF on the next cycle, but the old value 0 during the write cycle.
- **PC sequencing.** `inc_pc` ×3 from 0 → `pc_out`=6. Then `ld_pc` with 0x0000_0101 plus `inc_pc` in the same cycle → `pc_out`=0x0000_0100, `wr_conflict`=0. Then PC=0xFFFF_FFFE with `inc_pc` → 0.
- **Collision.** `ld_sp` + `ld_rd`@13, `wr_data`=0x1234_5678 → `sp_out`=0x1234_5678, `wr_conflict`=1 for exactly one cycle, then 0.
- **PSR and mask writes.** `ld_apsr` `nzcv_in`=4'b1010, `ld_ipsr` `ipsr_in`=6'h3F, `ld_primask`=1, all in one cycle → `apsr_out`=0xA000_0000, `ipsr_out`=0x0000_003F, `primask_out`=1.
- **Reset mid-operation.** `rst` asserted in the same cycle as `ld_rd`@5=0xFFFF_FFFF and `ld_lr`=0 → R5=0, LR=0xFFFF_FFFF, `wr_conflict`=0.
